// File: rtl/uart_tx_pkg.sv
// Shared types for the UART packet transmitter: parity modes and FSM states.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } tx_state_t;

    function automatic logic parity_enabled(input parity_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derive from the registered level.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    import uart_tx_pkg::*;

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array is not reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_packet_engine.sv
// UART packet transmitter: packet sequencing, frame serialisation and input buffering.
// Every serial bit starts on a clock_enable tick, so each bit lasts exactly one tick interval.
module uart_tx_packet_engine #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 15,
    parameter int GAP_W      = 2
) (
    input  logic                          system_clock,
    input  logic                          rst,
    input  logic                          clock_enable,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_words,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic [GAP_W-1:0]              delay,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              data_counter,
    output logic [7:0]                    packet_counter,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    import uart_tx_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(DATA_W);

    tx_state_t          state;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  fifo_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [CNT_W-1:0]   num_words_q;
    logic [CNT_W-1:0]   sent_after;
    logic               par_en;
    logic               par_odd;
    logic               par_bit;
    logic               stop_q;
    logic               stop_cnt;
    logic [GAP_W-1:0]   delay_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [3:0]         bit_cnt;
    logic               frame_end;
    logic               more;

    assign wr_ready = !fifo_full;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (system_clock),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A frame ends on the tick closing its last stop bit (no gap) or its last gap bit.
    // The next word is popped on that same tick so back-to-back frames have no idle tick.
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        frame_end  = 1'b0;
        sent_after = data_counter;
        if (clock_enable) begin
            if (state == STOP && stop_cnt == stop_q) begin
                sent_after = data_counter + CNT_W'(1);
                frame_end  = (delay_q == '0);
            end else if (state == GAP && gap_cnt == delay_q) begin
                frame_end = 1'b1;
            end
        end
        more = (sent_after < num_words_q);
        pop  = clock_enable && !fifo_empty && (state == LOAD || (frame_end && more));
    end

    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tx             <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            data_counter   <= '0;
            packet_counter <= '0;
            shift_reg      <= '0;
            num_words_q    <= '0;
            par_en         <= 1'b0;
            par_odd        <= 1'b0;
            par_bit        <= 1'b0;
            stop_q         <= 1'b0;
            stop_cnt       <= 1'b0;
            delay_q        <= '0;
            gap_cnt        <= '0;
            bit_cnt        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && num_words != '0) begin
                        num_words_q  <= num_words;
                        par_en       <= parity_enabled(parity_mode_t'(parity_mode));
                        par_odd      <= (parity_mode_t'(parity_mode) == PAR_ODD);
                        stop_q       <= stop_bits;
                        delay_q      <= delay;
                        data_counter <= '0;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                START: begin
                    if (clock_enable) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= 4'd1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (clock_enable) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (par_en) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (clock_enable) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (clock_enable) begin
                        if (stop_cnt == stop_q) begin
                            data_counter <= sent_after;
                            if (delay_q != '0) begin
                                gap_cnt <= GAP_W'(1);
                                state   <= GAP;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (clock_enable && gap_cnt != delay_q) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase

            if (frame_end) begin
                if (more) begin
                    state <= LOAD;
                end else begin
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    packet_counter <= packet_counter + 8'd1;
                    state          <= IDLE;
                end
            end

            // Launch a frame: load the word, latch its parity, drive the start bit.
            if (pop) begin
                shift_reg <= fifo_data;
                par_bit   <= par_odd ? ~^fifo_data : ^fifo_data;
                tx        <= 1'b0;
                state     <= START;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_packet_engine.sv
// Self-checking bench for uart_tx_packet_engine: vector table, directed corner cases, random packets.
`timescale 1ns/1ps
module tb_uart_tx_packet_engine;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 15;
    localparam int GAP_W      = 2;

    logic                 system_clock = 1'b0;
    logic                 rst;
    logic                 clock_enable;
    logic                 start;
    logic [CNT_W-1:0]     num_words;
    logic [1:0]           parity_mode;
    logic                 stop_bits;
    logic [GAP_W-1:0]     delay;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic                 tx;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     data_counter;
    logic [7:0]           packet_counter;
    logic [4:0]           fifo_level;

    uart_tx_packet_engine #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W),
        .GAP_W      (GAP_W)
    ) dut (
        .system_clock   (system_clock),
        .rst            (rst),
        .clock_enable   (clock_enable),
        .start          (start),
        .num_words      (num_words),
        .parity_mode    (parity_mode),
        .stop_bits      (stop_bits),
        .delay          (delay),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .tx             (tx),
        .busy           (busy),
        .done           (done),
        .data_counter   (data_counter),
        .packet_counter (packet_counter),
        .fifo_level     (fifo_level)
    );

    always #5 system_clock = ~system_clock;

    int checks    = 0;
    int passes    = 0;
    int ce_div    = 4;
    int cyc       = 0;
    int pkt_model = 0;
    int done_cnt  = 0;
    int busy_gap  = 0;
    bit rec_en    = 1'b0;
    bit rec_q[$];
    bit exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  pmode;
        logic        stop;
        logic [1:0]  dly;
        int          len;
        logic [15:0] bits;
    } vec_t;

    // Baud tick generator: clock_enable high on every ce_div-th cycle, changed on falling edges.
    initial begin
        clock_enable = 1'b0;
        forever begin
            @(negedge system_clock);
            cyc++;
            clock_enable = ((cyc % ce_div) == 0);
        end
    end

    // Line recorder: one tx sample per tick until the done pulse of the current packet.
    initial begin
        forever begin
            @(posedge system_clock);
            #1;
            if (rec_en) begin
                if (done) begin
                    done_cnt++;
                end else if (done_cnt == 0) begin
                    if (!busy) busy_gap++;
                    if (clock_enable) rec_q.push_back(tx);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits, idle gap.
    task automatic model_frame(input logic [7:0] w, input logic [1:0] pm, input logic sb,
                               input logic [1:0] dl);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) exp_q.push_back(w[i]);
        if (pm == 2'b01) exp_q.push_back(^w);
        else if (pm == 2'b10) exp_q.push_back(~^w);
        repeat (sb ? 2 : 1) exp_q.push_back(1'b1);
        repeat (int'(dl)) exp_q.push_back(1'b1);
    endtask

    task automatic push_word(input logic [7:0] w);
        @(negedge system_clock);
        wr_data  = w;
        wr_valid = 1'b1;
        @(negedge system_clock);
        wr_valid = 1'b0;
    endtask

    task automatic start_packet(input int n, input logic [1:0] pm, input logic sb,
                                input logic [1:0] dl);
        rec_q.delete();
        done_cnt = 0;
        busy_gap = 0;
        @(negedge system_clock);
        start       = 1'b1;
        num_words   = CNT_W'(n);
        parity_mode = pm;
        stop_bits   = sb;
        delay       = dl;
        @(negedge system_clock);
        start  = 1'b0;
        rec_en = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge system_clock);
            n++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (4 * ce_div + 4) @(negedge system_clock);
        rec_en = 1'b0;
        check({name, "_done_once"}, done_cnt, 1);
        check({name, "_busy_span"}, busy_gap, 0);
    endtask

    task automatic compare_stream(input string name);
        int mis = 0;
        check({name, "_len"}, rec_q.size(), exp_q.size());
        for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++)
            if (rec_q[i] !== exp_q[i]) mis++;
        check({name, "_bit_errors"}, mis, 0);
    endtask

    task automatic packet_done(input string name, input int words);
        pkt_model = (pkt_model + 1) % 256;
        check({name, "_data_counter"}, data_counter, words);
        check({name, "_packet_counter"}, packet_counter, pkt_model);
    endtask

    task automatic test_table();
        vec_t vecs[6];
        vecs[0] = '{8'hA5, 2'b00, 1'b0, 2'd0, 10, 16'h034A};
        vecs[1] = '{8'h07, 2'b01, 1'b0, 2'd0, 11, 16'h060E};
        vecs[2] = '{8'h07, 2'b10, 1'b0, 2'd0, 11, 16'h040E};
        vecs[3] = '{8'h07, 2'b01, 1'b1, 2'd0, 12, 16'h0E0E};
        vecs[4] = '{8'hA5, 2'b00, 1'b0, 2'd2, 12, 16'h0F4A};
        vecs[5] = '{8'h3C, 2'b10, 1'b1, 2'd1, 13, 16'h1E78};
        ce_div = 4;
        for (int v = 0; v < 6; v++) begin
            logic [15:0] got = '0;
            string nm = $sformatf("vec%0d", v);
            push_word(vecs[v].data);
            start_packet(1, vecs[v].pmode, vecs[v].stop, vecs[v].dly);
            wait_done(nm);
            for (int i = 0; i < rec_q.size() && i < 16; i++) got[i] = rec_q[i];
            check({nm, "_len"}, rec_q.size(), vecs[v].len);
            check({nm, "_bits"}, got, vecs[v].bits);
            packet_done(nm, 1);
        end
    endtask

    task automatic test_multi();
        logic [7:0] w;
        ce_div = 2;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom_range(0, 255));
            push_word(w);
            model_frame(w, 2'b00, 1'b0, 2'd2);
        end
        start_packet(3, 2'b00, 1'b0, 2'd2);
        repeat (6) @(negedge system_clock);
        start     = 1'b1;
        num_words = CNT_W'(5);
        @(negedge system_clock);
        start = 1'b0;
        wait_done("multi");
        compare_stream("multi");
        packet_done("multi", 3);
    endtask

    task automatic test_underrun();
        int n;
        int mis   = 0;
        int highs = 0;
        logic [7:0] wa = 8'h5A;
        logic [7:0] wb = 8'hC3;
        ce_div = 4;
        push_word(wa);
        start_packet(2, 2'b00, 1'b0, 2'd0);
        repeat (60 * 4) @(negedge system_clock);
        check("underrun_busy", busy, 1);
        check("underrun_tx_idle", tx, 1);
        check("underrun_count1", data_counter, 1);
        push_word(wb);
        wait_done("underrun");
        n = rec_q.size();
        check("underrun_long", 32'(n >= 60), 32'd1);
        exp_q.delete();
        model_frame(wa, 2'b00, 1'b0, 2'd0);
        for (int i = 0; i < 10 && i < n; i++) if (rec_q[i] !== exp_q[i]) mis++;
        exp_q.delete();
        model_frame(wb, 2'b00, 1'b0, 2'd0);
        for (int i = 0; i < 10 && n >= 10; i++) if (rec_q[n - 10 + i] !== exp_q[i]) mis++;
        for (int i = 10; i < n - 10; i++) if (rec_q[i] === 1'b1) highs++;
        check("underrun_frames", mis, 0);
        check("underrun_held_high", highs, (n > 20) ? n - 20 : 0);
        packet_done("underrun", 2);
    endtask

    task automatic test_random();
        logic [7:0] w;
        int         n;
        logic [1:0] pm;
        logic       sb;
        logic [1:0] dl;
        for (int it = 0; it < 8; it++) begin
            string nm = $sformatf("rand%0d", it);
            ce_div = $urandom_range(1, 3);
            n  = $urandom_range(1, 4);
            pm = 2'($urandom_range(0, 3));
            sb = 1'($urandom_range(0, 1));
            dl = 2'($urandom_range(0, 3));
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                w = 8'($urandom_range(0, 255));
                push_word(w);
                model_frame(w, pm, sb, dl);
            end
            start_packet(n, pm, sb, dl);
            wait_done(nm);
            compare_stream(nm);
            packet_done(nm, n);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] w5 [16];
        int n = 0;
        ce_div = 4;
        for (int i = 0; i < 16; i++) w5[i] = 8'($urandom_range(0, 255));
        w5[1] = 8'h00;
        for (int i = 0; i < 16; i++) push_word(w5[i]);
        check("full_level", fifo_level, 16);
        check("full_ready", wr_ready, 0);
        @(negedge system_clock);
        wr_data  = 8'hEE;
        wr_valid = 1'b1;
        @(negedge system_clock);
        wr_valid = 1'b0;
        check("full_drop_level", fifo_level, 16);
        exp_q.delete();
        model_frame(w5[0], 2'b00, 1'b0, 2'd0);
        start_packet(1, 2'b00, 1'b0, 2'd0);
        while (fifo_level == 5'd16 && n < 200) begin
            @(negedge system_clock);
            n++;
        end
        check("pop_level", fifo_level, 15);
        check("pop_ready", wr_ready, 1);
        wait_done("full_pkt");
        compare_stream("full_pkt");
        packet_done("full_pkt", 1);
    endtask

    task automatic test_reset();
        int n = 0;
        ce_div = 4;
        start_packet(3, 2'b00, 1'b0, 2'd0);
        while (rec_q.size() < 4 && n < 400) begin
            @(negedge system_clock);
            n++;
        end
        rec_en = 1'b0;
        #2;
        check("pre_rst_tx", tx, 0);
        rst = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_done", done, 0);
        check("rst_data_counter", data_counter, 0);
        check("rst_packet_counter", packet_counter, 0);
        @(negedge system_clock);
        rst = 1'b0;
        pkt_model = 0;
        @(negedge system_clock);
        start     = 1'b1;
        num_words = '0;
        @(negedge system_clock);
        start = 1'b0;
        repeat (12) @(negedge system_clock);
        check("zero_words_busy", busy, 0);
        check("zero_words_tx", tx, 1);
        check("zero_words_packets", packet_counter, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_words   = '0;
        parity_mode = 2'b00;
        stop_bits   = 1'b0;
        delay       = '0;
        wr_data     = '0;
        wr_valid    = 1'b0;
        #22;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_data_counter", data_counter, 0);
        check("reset_packet_counter", packet_counter, 0);
        check("reset_level", fifo_level, 0);
        check("reset_ready", wr_ready, 1);
        @(negedge system_clock);
        rst = 1'b0;
        repeat (2) @(negedge system_clock);

        test_table();
        test_multi();
        test_underrun();
        test_random();
        test_fifo_full();
        test_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
